// File: rtl/ttl_arb_pkg.sv
// ttl_arb_pkg: state encoding and sizing helper shared by the NOR share arbiter files.
package ttl_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, DONE = 2'd2} arb_state_e;
  function automatic int clog2(input int n);
    int r;
    for (r = 1; (1 << r) < n; r++) ;
    return r;
  endfunction
endpackage

// File: rtl/ttl_7427.sv
// ttl_7427: array of BLOCKS WIDTH_IN-input NOR gates, zero-delay functional model.
module ttl_7427 #(
  parameter int BLOCKS     = 3,
  parameter int WIDTH_IN   = 3,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
)(
  input  logic [BLOCKS*WIDTH_IN-1:0] A_2D,
  output logic [BLOCKS-1:0]          Y
);
  for (genvar b = 0; b < BLOCKS; b++) begin : g_gate
    assign Y[b] = ~|A_2D[b*WIDTH_IN +: WIDTH_IN];
  end
  // board delays are absorbed by the arbiter's hold window, not modelled here
  if (DELAY_RISE + DELAY_FALL > 0) begin : g_delay_unmodelled
  end
endmodule

// File: rtl/ttl_rr_pick.sv
// ttl_rr_pick: combinational round-robin picker, first set request at or above ptr.
module ttl_rr_pick import ttl_arb_pkg::*; #(
  parameter int REQUESTERS = 3,
  localparam int SW = clog2(REQUESTERS)
)(
  input  logic [REQUESTERS-1:0] req,
  input  logic [SW-1:0]         ptr,
  output logic [SW-1:0]         sel,
  output logic                  valid
);
  always_comb begin
    int k;
    sel = '0;
    for (int i = REQUESTERS - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % REQUESTERS;
      sel = req[SW'(k)] ? SW'(k) : sel;
    end
  end
  assign valid = |req;
endmodule

// File: rtl/ttl_nor_share_arbiter.sv
// ttl_nor_share_arbiter: round-robin share of one ttl_7427 among REQUESTERS clients.
// Optional TTL_ARB_LOCK_EN adds a Lock input that re-grants the last winner.
module ttl_nor_share_arbiter import ttl_arb_pkg::*; #(
  parameter int REQUESTERS  = 3,
  parameter int BLOCKS      = 3,
  parameter int WIDTH_IN    = 3,
  parameter int HOLD_CYCLES = 2,
  parameter int DELAY_RISE  = 0,
  parameter int DELAY_FALL  = 0
)(
  input  logic                                 Clk,
  input  logic                                 Clear_bar,
  input  logic [REQUESTERS-1:0]                Req,
  input  logic [REQUESTERS*BLOCKS*WIDTH_IN-1:0] A_2D,
`ifdef TTL_ARB_LOCK_EN
  input  logic                                 Lock,
`endif
  output logic [REQUESTERS-1:0]                Grant,
  output logic                                 Done,
  output logic [BLOCKS-1:0]                    Y
);
  localparam int SW = clog2(REQUESTERS);
  localparam int CW = clog2(HOLD_CYCLES);
  localparam int BW = BLOCKS * WIDTH_IN;
  arb_state_e state, state_n;
  logic [SW-1:0] sel, sel_n, ptr, ptr_n, pick, sel_inc;
  logic [CW-1:0] cnt, cnt_n;
  logic [REQUESTERS-1:0] grant_n;
  logic [BLOCKS-1:0] y_n, gate_y;
  logic [BW-1:0] ops [REQUESTERS];
  logic [BW-1:0] gate_a;
  logic valid, keep;
  for (genvar r = 0; r < REQUESTERS; r++) begin : g_ops
    assign ops[r] = A_2D[r*BW +: BW];
  end
  ttl_rr_pick #(.REQUESTERS(REQUESTERS)) u_pick (
    .req(Req), .ptr(ptr), .sel(pick), .valid(valid)
  );
  // idle gate sees all-zero inputs; its all-ones output is never captured there
  assign gate_a = (state == IDLE) ? '0 : ops[sel];
  ttl_7427 #(
    .BLOCKS(BLOCKS), .WIDTH_IN(WIDTH_IN), .DELAY_RISE(DELAY_RISE), .DELAY_FALL(DELAY_FALL)
  ) u_gate (
    .A_2D(gate_a), .Y(gate_y)
  );
  assign sel_inc = (sel == SW'(REQUESTERS - 1)) ? '0 : sel + 1'b1;
  assign Done = state == DONE;
`ifdef TTL_ARB_LOCK_EN
  assign keep = Lock;
`else
  assign keep = 1'b0;
`endif
  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      state <= IDLE;
      sel   <= '0;
      ptr   <= '0;
      cnt   <= '0;
      Grant <= '0;
      Y     <= '0;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      Grant <= grant_n;
      Y     <= y_n;
    end
  end
  always_comb begin
    state_n = state;
    sel_n   = sel;
    ptr_n   = ptr;
    cnt_n   = cnt;
    grant_n = Grant;
    y_n     = Y;
    case (state)
      IDLE: if (valid) begin
        state_n = SETTLE;
        sel_n   = pick;
        grant_n = REQUESTERS'(1) << pick;
        cnt_n   = CW'(HOLD_CYCLES - 1);
      end
      SETTLE: if (!Req[sel]) begin
        state_n = IDLE;
        grant_n = '0;
        ptr_n   = sel_inc;
      end else if (cnt == '0) begin
        state_n = DONE;
        y_n     = gate_y;
      end else begin
        cnt_n = cnt - 1'b1;
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        ptr_n   = keep ? sel : sel_inc;
      end
    endcase
  end
endmodule

// File: tb/tb_ttl_nor_share_arbiter.sv
// tb_ttl_nor_share_arbiter: directed scenarios for the shared NOR arbiter (3 clients, hold 2).
module tb_ttl_nor_share_arbiter;
  logic        Clk;
  logic        Clear_bar;
  logic [2:0]  Req;
  logic [26:0] A_2D;
  logic [2:0]  Grant;
  logic        Done;
  logic [2:0]  Y;
`ifdef TTL_ARB_LOCK_EN
  logic        Lock;
`endif
  int errors;
  int checks;

  ttl_nor_share_arbiter #(
    .REQUESTERS(3), .BLOCKS(3), .WIDTH_IN(3), .HOLD_CYCLES(2), .DELAY_RISE(0), .DELAY_FALL(0)
  ) dut (
    .Clk(Clk),
    .Clear_bar(Clear_bar),
    .Req(Req),
    .A_2D(A_2D),
`ifdef TTL_ARB_LOCK_EN
    .Lock(Lock),
`endif
    .Grant(Grant),
    .Done(Done),
    .Y(Y)
  );

  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      @(negedge Clk);
      ok = (Done === 1'b1);
    end
  endtask

  task automatic pulse_reset();
    @(negedge Clk);
    Req = '0;
    Clear_bar = 1'b0;
    @(negedge Clk);
    Clear_bar = 1'b1;
  endtask

  task automatic test_reset();
    bit ok;
    bit seen;
    @(negedge Clk);
    checks++; if (Grant !== 3'b000) begin errors++; $display("FAIL reset_grant got %b want 000", Grant); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", Done); end
    checks++; if (Y !== 3'b000) begin errors++; $display("FAIL reset_y got %b want 000", Y); end
    Clear_bar = 1'b1;
    Req = 3'b100;
    wait_done(ok);
    checks++; if (!ok || Y !== 3'b011) begin errors++; $display("FAIL reset_pre_op done=%b y=%b want 1 011", ok, Y); end
    Req = '0;
    @(negedge Clk);
    Req = 3'b001;
    @(negedge Clk);
    checks++; if (Grant !== 3'b001) begin errors++; $display("FAIL reset_pre_grant got %b want 001", Grant); end
    #1 Clear_bar = 1'b0;
    #1;
    checks++; if (Grant !== 3'b000) begin errors++; $display("FAIL reset_mid_grant got %b want 000", Grant); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_mid_done got %b want 0", Done); end
    checks++; if (Y !== 3'b000) begin errors++; $display("FAIL reset_mid_y got %b want 000", Y); end
    @(negedge Clk);
    Clear_bar = 1'b1;
    Req = '0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge Clk);
      seen |= (Done !== 1'b0);
    end
    checks++; if (seen || Y !== 3'b000) begin errors++; $display("FAIL reset_no_done seen=%b y=%b want 0 000", seen, Y); end
  endtask

  task automatic test_single();
    pulse_reset();
    Req = 3'b001;
    @(negedge Clk);
    checks++; if (Grant !== 3'b001 || Done !== 1'b0) begin errors++; $display("FAIL single_c1 grant=%b done=%b want 001 0", Grant, Done); end
    @(negedge Clk);
    checks++; if (Grant !== 3'b001 || Done !== 1'b0) begin errors++; $display("FAIL single_c2 grant=%b done=%b want 001 0", Grant, Done); end
    @(negedge Clk);
    checks++; if (Done !== 1'b1) begin errors++; $display("FAIL single_done got %b want 1", Done); end
    checks++; if (Y !== 3'b111) begin errors++; $display("FAIL single_y got %b want 111", Y); end
    checks++; if (Grant !== 3'b001) begin errors++; $display("FAIL single_grant_done got %b want 001", Grant); end
    Req = '0;
    @(negedge Clk);
    checks++; if (Grant !== 3'b000 || Done !== 1'b0) begin errors++; $display("FAIL single_after grant=%b done=%b want 000 0", Grant, Done); end
    checks++; if (Y !== 3'b111) begin errors++; $display("FAIL single_y_hold got %b want 111", Y); end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [2:0] exp_g [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [2:0] exp_y [4] = '{3'b111, 3'b110, 3'b011, 3'b111};
    pulse_reset();
    Req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      wait_done(ok);
      checks++; if (!ok || Grant !== exp_g[i]) begin errors++; $display("FAIL rr_grant%0d done=%b got %b want %b", i, ok, Grant, exp_g[i]); end
      checks++; if (Y !== exp_y[i]) begin errors++; $display("FAIL rr_y%0d got %b want %b", i, Y, exp_y[i]); end
    end
    Req = '0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_abort();
    bit ok;
    bit seen;
    pulse_reset();
    Req = 3'b001;
    wait_done(ok);
    checks++; if (!ok || Y !== 3'b111) begin errors++; $display("FAIL abort_pre done=%b y=%b want 1 111", ok, Y); end
    Req = '0;
    @(negedge Clk);
    Req = 3'b010;
    @(negedge Clk);
    checks++; if (Grant !== 3'b010) begin errors++; $display("FAIL abort_grant got %b want 010", Grant); end
    Req = '0;
    @(negedge Clk);
    checks++; if (Grant !== 3'b000 || Done !== 1'b0) begin errors++; $display("FAIL abort_drop grant=%b done=%b want 000 0", Grant, Done); end
    checks++; if (Y !== 3'b111) begin errors++; $display("FAIL abort_y got %b want 111", Y); end
    seen = 1'b0;
    repeat (4) begin
      @(negedge Clk);
      seen |= (Done !== 1'b0);
    end
    checks++; if (seen) begin errors++; $display("FAIL abort_no_done got 1 want 0"); end
    Req = 3'b011;
    @(negedge Clk);
    checks++; if (Grant !== 3'b001) begin errors++; $display("FAIL abort_next_grant got %b want 001", Grant); end
    wait_done(ok);
    checks++; if (!ok || Y !== 3'b111) begin errors++; $display("FAIL abort_next_done done=%b y=%b want 1 111", ok, Y); end
    Req = '0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_persistent();
    bit ok;
    logic [2:0] exp_g [3] = '{3'b001, 3'b010, 3'b001};
    logic [2:0] exp_y [3] = '{3'b111, 3'b110, 3'b111};
    pulse_reset();
    Req = 3'b011;
    for (int i = 0; i < 3; i++) begin
      wait_done(ok);
      checks++; if (!ok || Grant !== exp_g[i]) begin errors++; $display("FAIL persist_grant%0d done=%b got %b want %b", i, ok, Grant, exp_g[i]); end
      checks++; if (Y !== exp_y[i]) begin errors++; $display("FAIL persist_y%0d got %b want %b", i, Y, exp_y[i]); end
    end
    Req = '0;
    repeat (2) @(negedge Clk);
  endtask

`ifdef TTL_ARB_LOCK_EN
  task automatic test_lock();
    bit ok;
    pulse_reset();
    Req = 3'b011;
    Lock = 1'b1;
    wait_done(ok);
    checks++; if (!ok || Grant !== 3'b001) begin errors++; $display("FAIL lock_first done=%b got %b want 001", ok, Grant); end
    @(negedge Clk);
    Lock = 1'b0;
    wait_done(ok);
    checks++; if (!ok || Grant !== 3'b001) begin errors++; $display("FAIL lock_regrant done=%b got %b want 001", ok, Grant); end
    wait_done(ok);
    checks++; if (!ok || Grant !== 3'b010) begin errors++; $display("FAIL lock_release done=%b got %b want 010", ok, Grant); end
    Req = '0;
    repeat (2) @(negedge Clk);
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    Clk = 1'b0;
    Clear_bar = 1'b0;
    Req = '0;
    A_2D = {9'h040, 9'h001, 9'h000};
`ifdef TTL_ARB_LOCK_EN
    Lock = 1'b0;
`endif
    test_reset();
    test_single();
    test_round_robin();
    test_abort();
    test_persistent();
`ifdef TTL_ARB_LOCK_EN
    test_lock();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
